// File: rtl/upsampler.sv
// Zero-stuffing interpolator: emits each input sample followed by FACTOR-1 zeros.
// Define UPSAMPLER_HOLD_EN for zero-order-hold mode, which repeats the sample instead of inserting zeros.
module upsampler #(
    parameter int DATA_W = 4,
    parameter int FACTOR = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    localparam int PH_W = (FACTOR > 1) ? $clog2(FACTOR) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(FACTOR - 1);

    generate
        if (FACTOR < 1 || FACTOR > 256) begin : g_bad_factor
            $error("upsampler: FACTOR must be in 1..256");
        end
    endgenerate

    logic [PH_W-1:0] phase;

    // Wrap at FACTOR-1 rather than at 2**PH_W, so a non-power-of-2 FACTOR keeps an exact period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (phase == PH_LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + PH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= '0;
        end else if (phase == '0) begin
            data_out <= data_in;
        end else begin
`ifdef UPSAMPLER_HOLD_EN
            data_out <= data_out;
`else
            data_out <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_upsampler.sv
// Directed, table-driven bench for upsampler at FACTOR=4, 3 and 1.
// The expected values follow the build mode: zero-stuffing by default, zero-order hold when UPSAMPLER_HOLD_EN is defined.
module tb_upsampler;

`ifdef UPSAMPLER_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] din4 = '0, din3 = '0, din1 = '0;
    logic [3:0] out4, out3, out1;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    upsampler #(.DATA_W(4), .FACTOR(4)) u4 (.clk(clk), .rst(rst), .data_in(din4), .data_out(out4));
    upsampler #(.DATA_W(4), .FACTOR(3)) u3 (.clk(clk), .rst(rst), .data_in(din3), .data_out(out3));
    upsampler #(.DATA_W(4), .FACTOR(1)) u1 (.clk(clk), .rst(rst), .data_in(din1), .data_out(out1));

    typedef struct {
        logic       rst;
        logic [3:0] din;
        logic [3:0] exp_z;
        logic [3:0] exp_h;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] pick(input logic [3:0] z, input logic [3:0] h);
        return HOLD ? h : z;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held for two edges, then a period of 1010 with a change to 0110 at phase 2.
        vecs[0]  = '{1'b0, 4'b1010, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b0, 4'b1010, 4'b0000, 4'b0000};
        vecs[2]  = '{1'b1, 4'b1010, 4'b1010, 4'b1010};
        vecs[3]  = '{1'b1, 4'b1010, 4'b0000, 4'b1010};
        vecs[4]  = '{1'b1, 4'b0110, 4'b0000, 4'b1010};
        vecs[5]  = '{1'b1, 4'b0110, 4'b0000, 4'b1010};
        vecs[6]  = '{1'b1, 4'b0110, 4'b0110, 4'b0110};
        vecs[7]  = '{1'b1, 4'b0110, 4'b0000, 4'b0110};
        vecs[8]  = '{1'b1, 4'b0101, 4'b0000, 4'b0110};
        vecs[9]  = '{1'b1, 4'b0101, 4'b0000, 4'b0110};
        vecs[10] = '{1'b1, 4'b0101, 4'b0101, 4'b0101};
        vecs[11] = '{1'b1, 4'b1111, 4'b0000, 4'b0101};

        #1;
        check("reset_t0", out4, 4'b0000);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst  = vecs[i].rst;
            din4 = vecs[i].din;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), out4, pick(vecs[i].exp_z, vecs[i].exp_h));
        end

        // Mid-period reset at phase 2: the output clears without an edge, and the period restarts at phase 0.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_async", out4, 4'b0000);
        #1;
        rst  = 1'b1;
        din4 = 4'b0011;
        @(posedge clk); #1;
        check("midrst_ph0", out4, 4'b0011);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("midrst_ph%0d", i), out4, pick(4'b0000, 4'b0011));
        end
        @(posedge clk); #1;
        check("midrst_next_ph0", out4, 4'b0011);

        // Assert reset between edges while the output is nonzero; it must clear at once.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_clear", out4, 4'b0000);

        // FACTOR=3
        din3 = 4'b0110;
        @(negedge clk);
        check("f3_reset", out3, 4'b0000);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("f3_e%0d", i), out3, (i % 3 == 0) ? 4'b0110 : pick(4'b0000, 4'b0110));
        end

        // FACTOR=1: a one-cycle register in both modes
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("f1_reset", out1, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [3:0] v;
            v = 4'(4'b1001 + 4'(i * 5));
            din1 = v;
            @(posedge clk); #1;
            check($sformatf("f1_e%0d", i), out1, v);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/upsampler.md
Name: upsampler

Overview:
- Zero-stuffing interpolator for the 64-QAM modulator transmit path. Sits between the symbol mapper and the pulse-shaping filter.
- Inserts FACTOR-1 zero samples after each input sample, so the output sample rate is FACTOR times the symbol rate on the same clock.
- The input is sampled once every FACTOR clocks. The output is fully registered.

Parameters:
- DATA_W, default 4: width of data_in and data_out in bits.
- FACTOR, default 4: upsampling ratio L. Legal range 1..256.

Ports:
- clk, input, 1: system clock. All logic is rising-edge.
- rst, input, 1: asynchronous, active-low reset. rst=0 resets the block; rst=1 is normal operation.
- data_in, input, DATA_W: input symbol component. Sampled only on phase-0 clocks.
- data_out, output, DATA_W: upsampled stream. Registered.

Behaviour:
- State:
  - phase counter, width max(1, clog2(FACTOR)) bits, counts 0..FACTOR-1.
  - data_out register.
- Reset (rst=0), asynchronous, takes effect immediately without a clock edge:
  - phase=0, data_out=0.
  - Reset held: outputs stay 0 and data_in is ignored.
- Each rising edge with rst=1:
  - If phase==0: data_out <= data_in.
  - Else: data_out <= 0 (all DATA_W bits zero).
  - Phase update: phase <= (phase==FACTOR-1) ? 0 : phase+1. The wrap-around is exact, so no stray states occur for non-power-of-2 FACTOR.
- Latency:
  - data_in present before edge k (phase 0) appears on data_out from edge k until edge k+1.
  - It is followed by exactly FACTOR-1 zero cycles.
- First edge after reset release is always phase 0. The first output sample is data_in at that edge.
- data_in changes during phases 1..FACTOR-1 have no effect on output. No internal input buffering.
- FACTOR=1: block is a one-cycle register pass-through (phase stays 0).
- Reset asserted mid-period: phase and output clear immediately. Period restarts at phase 0 on the first edge after release.
- No overflow/underflow conditions. Data is passed unmodified with no arithmetic; sign interpretation is irrelevant.
- Illegal FACTOR (<1 or >256): elaboration-time error via a generate-time check.

Optional Feature:
- Macro UPSAMPLER_HOLD_EN.
- Defined: zero-order-hold mode.
  - On phase 0, data_in is captured into data_out.
  - On phases 1..FACTOR-1, data_out holds its previous value instead of going to 0.
  - Reset value is still 0.
- Undefined (default): zero-stuffing as specified in Behaviour.
- Phase counter behaviour and latency are identical in both modes.

Test Plan:
- Reset check: rst=0 with data_in=4'b1010, clock running -> data_out=4'b0000 throughout. Asserting rst=0 between edges clears data_out immediately.
- Basic zero-stuffing: FACTOR=4, rst=1 with data_in=4'b1010 held -> data_out sequence from first edge is 1010,0000,0000,0000,1010,0000,0000,0000...
- Input change mid-period: data_in changes 1010->0110 while phase=2 -> output stays 0000 until the next phase-0 edge, then 0110 followed by three 0000.
- Reset mid-period: release reset, run 2 edges (phase=2), pull rst low then high -> next edge outputs the current data_in (phase 0), followed by three zeros.
- FACTOR=3 and FACTOR=1 builds:
  - FACTOR=3, data_in=0110 -> 0110,0000,0000 repeating.
  - FACTOR=1 -> data_out equals data_in delayed one clock every cycle.
- UPSAMPLER_HOLD_EN defined, FACTOR=4: data_in=1010 then 0110 at phase 2 -> 1010,1010,1010,1010,0110,0110,...
